// File: rtl/key_sw_io_device.sv
// Memory-mapped KEY/SW input device: two-flop synchronizers, per-group debounce,
// data and control/status registers with sticky ready/overrun and a registered interrupt.

module key_sw_debounce #(
  parameter int W               = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_BITS        = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] raw_i,
  output logic [W-1:0] deb_o,
  output logic         upd_o
);
  localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(DEBOUNCE_CYCLES - 1);

  logic [W-1:0]        sync1_q, sync2_q;
  logic [W-1:0]        cand_q, cand_d;
  logic [W-1:0]        deb_q, deb_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                upd;

  // Any disagreement with the candidate restarts the stability window.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
    upd   = (cnt_q == CNT_MAX) && (cand_q == sync2_q) && (cand_q != deb_q);
    deb_d = upd ? cand_q : deb_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      deb_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      deb_q   <= deb_d;
    end
  end

  assign deb_o = deb_q;
  assign upd_o = upd;
endmodule

module key_sw_io_device #(
  parameter int                DBITS           = 32,
  parameter int                DEBOUNCE_CYCLES = 500000,
  parameter int                CNT_BITS        = 20,
  parameter logic [DBITS-1:0]  ADDR_KDATA      = 32'hF0000010,
  parameter logic [DBITS-1:0]  ADDR_SDATA      = 32'hF0000014,
  parameter logic [DBITS-1:0]  ADDR_KCTRL      = 32'hF0000110,
  parameter logic [DBITS-1:0]  ADDR_SCTRL      = 32'hF0000114
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       KEY,
  input  logic [9:0]       SW,
  input  logic [DBITS-1:0] memAddr,
  input  logic             memWrEn,
  input  logic             memRdEn,
  input  logic [DBITS-1:0] memWrData,
  output logic [DBITS-1:0] memRdData,
  output logic             isDev,
  output logic             intr
);
  logic [3:0] k_deb;
  logic [9:0] s_deb;
  logic       k_upd, s_upd;

  // Keys are active-low on the board; invert so a pressed key reads as 1.
  key_sw_debounce #(.W(4), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_BITS(CNT_BITS)) u_key_deb (
    .clk(clk), .reset(reset), .raw_i(~KEY), .deb_o(k_deb), .upd_o(k_upd)
  );
  key_sw_debounce #(.W(10), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_BITS(CNT_BITS)) u_sw_deb (
    .clk(clk), .reset(reset), .raw_i(SW), .deb_o(s_deb), .upd_o(s_upd)
  );

  logic hit_kdata, hit_sdata, hit_kctrl, hit_sctrl;
  assign hit_kdata = (memAddr == ADDR_KDATA);
  assign hit_sdata = (memAddr == ADDR_SDATA);
  assign hit_kctrl = (memAddr == ADDR_KCTRL);
  assign hit_sctrl = (memAddr == ADDR_SCTRL);
  assign isDev     = hit_kdata | hit_sdata | hit_kctrl | hit_sctrl;

  logic k_ready_q, k_ready_d, k_ovr_q, k_ovr_d, k_ie_q, k_ie_d;
  logic s_ready_q, s_ready_d, s_ovr_q, s_ovr_d, s_ie_q, s_ie_d;
  logic intr_q, intr_d;
  logic k_ctrl_wr, s_ctrl_wr;

  assign k_ctrl_wr = memWrEn & hit_kctrl;
  assign s_ctrl_wr = memWrEn & hit_sctrl;

  // Hardware set events take priority over software clears in the same cycle.
  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    k_ready_d = k_ready_q;
    s_ready_d = s_ready_q;
    k_ovr_d   = k_ovr_q;
    s_ovr_d   = s_ovr_q;
    k_ie_d    = k_ie_q;
    s_ie_d    = s_ie_q;

    if (memRdEn && hit_kdata) k_ready_d = 1'b0;
    if (memRdEn && hit_sdata) s_ready_d = 1'b0;
    if (k_upd)                k_ready_d = 1'b1;
    if (s_upd)                s_ready_d = 1'b1;

    if (k_ctrl_wr) begin
      k_ie_d = memWrData[4];
      if (!memWrData[2]) k_ovr_d = 1'b0;
    end
    if (s_ctrl_wr) begin
      s_ie_d = memWrData[4];
      if (!memWrData[2]) s_ovr_d = 1'b0;
    end
    if (k_upd && k_ready_q) k_ovr_d = 1'b1;
    if (s_upd && s_ready_q) s_ovr_d = 1'b1;

    intr_d = (k_ready_q & k_ie_q) | (s_ready_q & s_ie_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      k_ready_q <= 1'b0;
      s_ready_q <= 1'b0;
      k_ovr_q   <= 1'b0;
      s_ovr_q   <= 1'b0;
      k_ie_q    <= 1'b0;
      s_ie_q    <= 1'b0;
      intr_q    <= 1'b0;
    end else begin
      k_ready_q <= k_ready_d;
      s_ready_q <= s_ready_d;
      k_ovr_q   <= k_ovr_d;
      s_ovr_q   <= s_ovr_d;
      k_ie_q    <= k_ie_d;
      s_ie_q    <= s_ie_d;
      intr_q    <= intr_d;
    end
  end

  assign intr = intr_q;

  always_comb begin
    memRdData = '0;
    if (hit_kdata)      memRdData = {{(DBITS-4){1'b0}}, k_deb};
    else if (hit_sdata) memRdData = {{(DBITS-10){1'b0}}, s_deb};
    else if (hit_kctrl) memRdData = {{(DBITS-5){1'b0}}, k_ie_q, 1'b0, k_ovr_q, 1'b0, k_ready_q};
    else if (hit_sctrl) memRdData = {{(DBITS-5){1'b0}}, s_ie_q, 1'b0, s_ovr_q, 1'b0, s_ready_q};
  end

  // Store-data bits with no register behind them.
  logic unused_wr_bits;
  assign unused_wr_bits = ^{memWrData[DBITS-1:5], memWrData[3], memWrData[1:0]};
endmodule

// File: tb/tb_key_sw_io_device.sv
// Directed bench for key_sw_io_device with a short debounce window (4 cycles).

module tb_key_sw_io_device;
  localparam logic [31:0] A_KDATA = 32'hF0000010;
  localparam logic [31:0] A_SDATA = 32'hF0000014;
  localparam logic [31:0] A_KCTRL = 32'hF0000110;
  localparam logic [31:0] A_SCTRL = 32'hF0000114;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  KEY;
  logic [9:0]  SW;
  logic [31:0] memAddr, memWrData, memRdData;
  logic        memWrEn, memRdEn, isDev, intr;

  int tests = 0;
  int fails = 0;

  key_sw_io_device #(.DBITS(32), .DEBOUNCE_CYCLES(4), .CNT_BITS(3)) dut (
    .clk(clk), .reset(reset), .KEY(KEY), .SW(SW),
    .memAddr(memAddr), .memWrEn(memWrEn), .memRdEn(memRdEn), .memWrData(memWrData),
    .memRdData(memRdData), .isDev(isDev), .intr(intr)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic peek(input logic [31:0] addr, input string tag, input logic [31:0] exp);
    memAddr = addr;
    memRdEn = 1'b0;
    #1;
    check(tag, memRdData, exp);
  endtask

  task automatic rd_clr(input logic [31:0] addr, input string tag, input logic [31:0] exp);
    memAddr = addr;
    memRdEn = 1'b1;
    #1;
    check(tag, memRdData, exp);
    tick(1);
    memRdEn = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    memAddr   = addr;
    memWrData = data;
    memWrEn   = 1'b1;
    tick(1);
    memWrEn   = 1'b0;
  endtask

  initial begin
    reset = 1'b1; KEY = 4'hF; SW = '0;
    memAddr = '0; memWrData = '0; memWrEn = 1'b0; memRdEn = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(20);

    // Idle after reset
    peek(A_KDATA, "idle_kdata", 32'h0);
    check("idle_isdev", {31'b0, isDev}, 32'h1);
    peek(A_SDATA, "idle_sdata", 32'h0);
    peek(A_KCTRL, "idle_kctrl", 32'h0);
    peek(A_SCTRL, "idle_sctrl", 32'h0);
    check("idle_intr", {31'b0, intr}, 32'h0);

    // Clean press of KEY[2], first sampled at edge N
    KEY = 4'hB;
    tick(6);
    peek(A_KDATA, "press_kdata_early", 32'h0);
    peek(A_KCTRL, "press_kctrl_early", 32'h0);
    tick(1);
    peek(A_KDATA, "press_kdata", 32'h4);
    peek(A_KCTRL, "press_kctrl", 32'h1);
    rd_clr(A_KDATA, "press_read", 32'h4);
    peek(A_KCTRL, "press_kctrl_cleared", 32'h0);

    // Bounce on SW[0]; last transition first sampled at edge N
    SW = 10'h001; tick(2);
    SW = 10'h000; tick(2);
    SW = 10'h001;
    tick(6);
    peek(A_SDATA, "bounce_sdata_early", 32'h0);
    peek(A_SCTRL, "bounce_sctrl_early", 32'h0);
    tick(1);
    peek(A_SDATA, "bounce_sdata", 32'h1);
    peek(A_SCTRL, "bounce_sctrl", 32'h1);

    // Overrun: two more updates without reading SDATA
    SW = 10'h3FF; tick(8);
    peek(A_SDATA, "ovr_sdata_3ff", 32'h3FF);
    peek(A_SCTRL, "ovr_sctrl_a", 32'h5);
    SW = 10'h000; tick(8);
    peek(A_SDATA, "ovr_sdata_0", 32'h0);
    peek(A_SCTRL, "ovr_sctrl_b", 32'h5);
    wr(A_SCTRL, 32'h0000_0004);
    peek(A_SCTRL, "ovr_keep_bit2_1", 32'h5);
    wr(A_SCTRL, 32'h0);
    peek(A_SCTRL, "ovr_cleared", 32'h1);
    rd_clr(A_SDATA, "ovr_read", 32'h0);
    peek(A_SCTRL, "ovr_ready_cleared", 32'h0);

    // Interrupt from keys
    wr(A_KCTRL, 32'h10);
    peek(A_KCTRL, "irq_ie", 32'h10);
    check("irq_idle", {31'b0, intr}, 32'h0);
    KEY = 4'hA;
    tick(7);
    peek(A_KCTRL, "irq_ready", 32'h11);
    check("irq_not_yet", {31'b0, intr}, 32'h0);
    tick(1);
    check("irq_rise", {31'b0, intr}, 32'h1);
    wr(A_KDATA, 32'hFFFF_FFFF);
    peek(A_KDATA, "store_kdata_ignored", 32'h5);
    peek(A_KCTRL, "store_kctrl_same", 32'h11);
    check("store_intr_same", {31'b0, intr}, 32'h1);
    rd_clr(A_KDATA, "irq_read", 32'h5);
    peek(A_KCTRL, "irq_ready_clr", 32'h10);
    check("irq_still_high", {31'b0, intr}, 32'h1);
    tick(1);
    check("irq_fall", {31'b0, intr}, 32'h0);

    // Collision: KDATA read on the edge where kDeb updates
    KEY = 4'hF;
    tick(6);
    rd_clr(A_KDATA, "coll_old_value", 32'h5);
    peek(A_KDATA, "coll_new_value", 32'h0);
    peek(A_KCTRL, "coll_ready_kept", 32'h11);
    tick(1);
    check("coll_intr", {31'b0, intr}, 32'h1);
    peek(32'hF0000018, "unmapped_data", 32'h0);
    check("unmapped_isdev", {31'b0, isDev}, 32'h0);

    // Reset mid-debounce, then held input re-qualifies
    SW = 10'h001;
    tick(3);
    reset = 1'b1;
    tick(1);
    peek(A_SDATA, "rst_sdata", 32'h0);
    peek(A_SCTRL, "rst_sctrl", 32'h0);
    peek(A_KCTRL, "rst_kctrl", 32'h0);
    reset = 1'b0;
    tick(6);
    peek(A_SDATA, "requal_early", 32'h0);
    tick(1);
    peek(A_SDATA, "requal_sdata", 32'h1);
    peek(A_SCTRL, "requal_sctrl", 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
